// File: rtl/udma_uart_rx_deframer.sv
// UART receive deframer: synchronises rx_i, strips start/parity/stop and hands
// characters to a valid/ready holding register. Optional: UDMA_UART_RX_MAJORITY_EN.
module udma_uart_rx_deframer #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 cfg_en_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic                 cfg_parity_en_i,
   input  logic [1:0]           cfg_bits_i,
   input  logic                 cfg_stop_bits_i,
   output logic                 busy_o,
   output logic                 err_parity_o,
   output logic                 err_overflow_o,
   output logic                 char_event_o,
   output logic [7:0]           rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic                 r_rx_meta;
   logic                 r_rxs;
   state_t               r_state;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic                 r_armed;
   logic [7:0]           r_shift;
   logic [2:0]           r_bit_idx;
   logic                 r_stop_idx;
   logic                 r_par;
   logic                 r_par_err;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid;
   logic                 r_char_event;
   logic                 r_err_parity;
   logic                 r_err_overflow;

   logic [DIV_WIDTH-1:0] w_mid;
   logic                 w_sample_pt;
   logic                 w_bit;
   logic [2:0]           w_last_idx;
   logic                 w_complete;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rxs     <= r_rx_meta;
      end
   end

   assign w_mid      = cfg_div_i >> 1;
   assign w_last_idx = {1'b0, cfg_bits_i} + 3'd4;

`ifdef UDMA_UART_RX_MAJORITY_EN
   logic r_maj_a;
   logic r_maj_b;

   // Capture the two earlier votes; the third is the live line at mid+1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_maj_a <= 1'b1;
         r_maj_b <= 1'b1;
      end else begin
         if (r_cnt == w_mid - ONE) r_maj_a <= r_rxs;
         if (r_cnt == w_mid)       r_maj_b <= r_rxs;
      end
   end

   assign w_sample_pt = (r_cnt == w_mid + ONE);
   assign w_bit       = (r_maj_a & r_maj_b) | (r_maj_a & r_rxs) | (r_maj_b & r_rxs);
`else
   assign w_sample_pt = (r_cnt == w_mid);
   assign w_bit       = r_rxs;
`endif

   assign w_complete = cfg_en_i && (r_state == ST_STOP) && w_sample_pt && w_bit &&
                       (r_stop_idx == cfg_stop_bits_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_armed        <= 1'b0;
         r_shift        <= 8'h00;
         r_bit_idx      <= 3'd0;
         r_stop_idx     <= 1'b0;
         r_par          <= 1'b0;
         r_par_err      <= 1'b0;
         r_rx_data      <= 8'h00;
         r_rx_valid     <= 1'b0;
         r_char_event   <= 1'b0;
         r_err_parity   <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_char_event   <= 1'b0;
         r_err_parity   <= 1'b0;
         r_err_overflow <= 1'b0;

         // A completion may load in the same cycle the old character leaves.
         if (w_complete) begin
            if (!r_rx_valid || rx_ready_i) begin
               r_rx_data    <= r_shift;
               r_rx_valid   <= 1'b1;
               r_char_event <= 1'b1;
            end else begin
               r_err_overflow <= 1'b1;
            end
            r_err_parity <= r_par_err;
         end else if (r_rx_valid && rx_ready_i) begin
            r_rx_valid <= 1'b0;
         end

         if (r_state != ST_IDLE) begin
            r_cnt <= (r_cnt == cfg_div_i) ? '0 : r_cnt + ONE;
         end

         if (!cfg_en_i) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // Armed only after the line has been seen high.
                  if (r_armed && !r_rxs) begin
                     r_state <= ST_START;
                     r_cnt   <= '0;
                     r_armed <= 1'b0;
                  end else begin
                     r_armed <= r_rxs;
                  end
               end
               ST_START: begin
                  if (w_sample_pt) begin
                     if (!w_bit) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= 3'd0;
                        r_shift   <= 8'h00;
                        r_par     <= 1'b0;
                        r_par_err <= 1'b0;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               ST_DATA: begin
                  if (w_sample_pt) begin
                     r_shift[r_bit_idx] <= w_bit;
                     r_par              <= r_par ^ w_bit;
                     if (r_bit_idx == w_last_idx) begin
                        r_state    <= cfg_parity_en_i ? ST_PARITY : ST_STOP;
                        r_stop_idx <= 1'b0;
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end
               end
               ST_PARITY: begin
                  if (w_sample_pt) begin
                     r_par_err <= r_par ^ w_bit;
                     r_state   <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  if (w_sample_pt) begin
                     if (!w_bit || (r_stop_idx == cfg_stop_bits_i)) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_stop_idx <= 1'b1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy_o         = (r_state != ST_IDLE);
   assign err_parity_o   = r_err_parity;
   assign err_overflow_o = r_err_overflow;
   assign char_event_o   = r_char_event;
   assign rx_data_o      = r_rx_data;
   assign rx_valid_o     = r_rx_valid;

endmodule

// File: tb/tb_udma_uart_rx_deframer.sv
// Directed bench for udma_uart_rx_deframer: vector table of whole frames plus
// hand-written glitch, framing, reset and disable sequences.
module tb_udma_uart_rx_deframer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        rx_i = 1'b1;
   logic        cfg_en_i = 1'b1;
   logic [15:0] cfg_div_i = 16'd9;
   logic        cfg_parity_en_i = 1'b0;
   logic [1:0]  cfg_bits_i = 2'b11;
   logic        cfg_stop_bits_i = 1'b0;
   logic        busy_o;
   logic        err_parity_o;
   logic        err_overflow_o;
   logic        char_event_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_ready_i = 1'b1;

   udma_uart_rx_deframer #(.DIV_WIDTH(16)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .rx_i            (rx_i),
      .cfg_en_i        (cfg_en_i),
      .cfg_div_i       (cfg_div_i),
      .cfg_parity_en_i (cfg_parity_en_i),
      .cfg_bits_i      (cfg_bits_i),
      .cfg_stop_bits_i (cfg_stop_bits_i),
      .busy_o          (busy_o),
      .err_parity_o    (err_parity_o),
      .err_overflow_o  (err_overflow_o),
      .char_event_o    (char_event_o),
      .rx_data_o       (rx_data_o),
      .rx_valid_o      (rx_valid_o),
      .rx_ready_i      (rx_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int n_char = 0;
   int n_par  = 0;
   int n_ovf  = 0;
   int n_xfer = 0;
   int n_busy = 0;

   always @(posedge clk_i) begin
      if (char_event_o)             n_char <= n_char + 1;
      if (err_parity_o)             n_par  <= n_par + 1;
      if (err_overflow_o)           n_ovf  <= n_ovf + 1;
      if (rx_valid_o && rx_ready_i) n_xfer <= n_xfer + 1;
      if (busy_o)                   n_busy <= n_busy + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx_i = v;
      repeat (int'(cfg_div_i) + 1) @(posedge clk_i);
      #1;
   endtask

   // Frame using the current configuration; line is left at the last stop level.
   task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
      logic p;
      int   nb;
      p  = 1'b0;
      nb = int'(cfg_bits_i) + 5;
      drive_bit(1'b0);
      for (int i = 0; i < nb; i++) begin
         drive_bit(data[i]);
         p = p ^ data[i];
      end
      if (cfg_parity_en_i) drive_bit(p ^ bad_par);
      drive_bit(~bad_stop);
      if (cfg_stop_bits_i && !bad_stop) drive_bit(1'b1);
   endtask

   typedef struct {
      logic [15:0] div;
      logic [1:0]  bits;
      logic        par_en;
      logic        stop2;
      logic [7:0]  data;
      logic        bad_par;
      logic        ready;
      logic [7:0]  exp_data;
      logic        exp_valid;
      int          exp_char;
      int          exp_par;
      int          exp_ovf;
   } vec_t;

   vec_t vecs[8];

   int c0, p0, o0, x0, b0;

   initial begin
      //           div    bits   par   st2   data   badp  rdy   exp    vld   ch par ovf
      vecs[0] = '{16'd9,  2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 0, 0};
      vecs[1] = '{16'd9,  2'b00, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1, 0, 0};
      vecs[2] = '{16'd9,  2'b00, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b1, 8'h1F, 1'b0, 1, 1, 0};
      vecs[3] = '{16'd9,  2'b01, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1, 0, 0};
      vecs[4] = '{16'd5,  2'b01, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1, 0, 0};
      vecs[5] = '{16'd15, 2'b10, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h43, 1'b0, 1, 0, 0};
      vecs[6] = '{16'd9,  2'b11, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 1, 0, 0};
      vecs[7] = '{16'd9,  2'b11, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b1, 0, 0, 1};

      idle(3);
      check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
      check("reset_data",  {24'd0, rx_data_o}, 32'd0);
      check("reset_busy",  {31'd0, busy_o}, 32'd0);
      check("reset_pulses", {29'd0, char_event_o, err_parity_o, err_overflow_o}, 32'd0);
      rst_i = 1'b0;
      idle(5);

      for (int v = 0; v < 8; v++) begin
         cfg_div_i       = vecs[v].div;
         cfg_bits_i      = vecs[v].bits;
         cfg_parity_en_i = vecs[v].par_en;
         cfg_stop_bits_i = vecs[v].stop2;
         rx_ready_i      = vecs[v].ready;
         idle(2);
         c0 = n_char; p0 = n_par; o0 = n_ovf; b0 = n_busy;
         send_frame(vecs[v].data, vecs[v].bad_par, 1'b0);
         idle(6);
         $display("vec %0d: sent 0x%02h -> data 0x%02h valid %0d char %0d par %0d ovf %0d",
                  v, vecs[v].data, rx_data_o, rx_valid_o, n_char - c0, n_par - p0, n_ovf - o0);
         check($sformatf("vec%0d_data", v),  {24'd0, rx_data_o}, {24'd0, vecs[v].exp_data});
         check($sformatf("vec%0d_valid", v), {31'd0, rx_valid_o}, {31'd0, vecs[v].exp_valid});
         check($sformatf("vec%0d_char", v),  n_char - c0, vecs[v].exp_char);
         check($sformatf("vec%0d_par", v),   n_par - p0, vecs[v].exp_par);
         check($sformatf("vec%0d_ovf", v),   n_ovf - o0, vecs[v].exp_ovf);
         check($sformatf("vec%0d_busy", v),  {31'd0, busy_o}, 32'd0);
         if (v == 0) check("vec0_busy_span", ((n_busy - b0) >= 90 && (n_busy - b0) <= 100) ? 32'd1 : 32'd0, 32'd1);
      end

      // Drain the held 0x11: exactly one transfer.
      x0 = n_xfer;
      rx_ready_i = 1'b1;
      idle(1);
      rx_ready_i = 1'b0;
      idle(2);
      $display("drain: data 0x%02h valid %0d xfers %0d", rx_data_o, rx_valid_o, n_xfer - x0);
      check("drain_xfer",  n_xfer - x0, 1);
      check("drain_valid", {31'd0, rx_valid_o}, 32'd0);
      check("drain_data",  {24'd0, rx_data_o}, 32'h11);

      // Glitch: 3-cycle low pulse at div 15.
      cfg_div_i = 16'd15; cfg_bits_i = 2'b11; cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0;
      rx_ready_i = 1'b1;
      idle(4);
      c0 = n_char; p0 = n_par; o0 = n_ovf; b0 = n_busy;
      rx_i = 1'b0;
      idle(3);
      rx_i = 1'b1;
      idle(40);
      $display("glitch: busy cycles %0d char %0d valid %0d", n_busy - b0, n_char - c0, rx_valid_o);
      check("glitch_seen",   (n_busy - b0 > 0) ? 32'd1 : 32'd0, 32'd1);
      check("glitch_idle",   {31'd0, busy_o}, 32'd0);
      check("glitch_events", (n_char - c0) + (n_par - p0) + (n_ovf - o0), 0);
      check("glitch_valid",  {31'd0, rx_valid_o}, 32'd0);
      c0 = n_char;
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(6);
      $display("glitch follow-up: data 0x%02h char %0d", rx_data_o, n_char - c0);
      check("glitch_next_data", {24'd0, rx_data_o}, 32'h3C);
      check("glitch_next_char", n_char - c0, 1);

      // Framing error on 0x55, line held low afterwards.
      cfg_div_i = 16'd9;
      idle(4);
      c0 = n_char; p0 = n_par; o0 = n_ovf; x0 = n_xfer;
      send_frame(8'h55, 1'b0, 1'b1);
      idle(40);
      $display("framing: busy %0d char %0d xfers %0d", busy_o, n_char - c0, n_xfer - x0);
      check("frame_busy",   {31'd0, busy_o}, 32'd0);
      check("frame_events", (n_char - c0) + (n_par - p0) + (n_ovf - o0), 0);
      check("frame_xfer",   n_xfer - x0, 0);
      rx_i = 1'b1;
      idle(20);
      c0 = n_char;
      send_frame(8'h0F, 1'b0, 1'b0);
      idle(6);
      $display("framing follow-up: data 0x%02h char %0d", rx_data_o, n_char - c0);
      check("frame_next_data", {24'd0, rx_data_o}, 32'h0F);
      check("frame_next_char", n_char - c0, 1);

      // Reset during data bit 4, with a character held.
      rx_ready_i = 1'b0;
      send_frame(8'h42, 1'b0, 1'b0);
      idle(4);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h81 >> i));
      rx_i = 1'b0;
      idle(4);
      rst_i = 1'b1;
      #1;
      $display("reset mid-frame: valid %0d data 0x%02h busy %0d", rx_valid_o, rx_data_o, busy_o);
      check("rst_mid_valid", {31'd0, rx_valid_o}, 32'd0);
      check("rst_mid_data",  {24'd0, rx_data_o}, 32'd0);
      check("rst_mid_busy",  {31'd0, busy_o}, 32'd0);
      idle(2);
      rst_i = 1'b0;
      rx_i = 1'b1;
      rx_ready_i = 1'b1;
      idle(20);
      c0 = n_char;
      send_frame(8'h81, 1'b0, 1'b0);
      idle(6);
      $display("after reset: data 0x%02h char %0d", rx_data_o, n_char - c0);
      check("rst_next_data", {24'd0, rx_data_o}, 32'h81);
      check("rst_next_char", n_char - c0, 1);

      // Disable during data bit 4, with 0x5A held.
      rx_ready_i = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b0);
      idle(4);
      c0 = n_char; o0 = n_ovf;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h77 >> i));
      rx_i = 1'b0;
      idle(3);
      cfg_en_i = 1'b0;
      idle(2);
      $display("disable mid-frame: busy %0d valid %0d data 0x%02h", busy_o, rx_valid_o, rx_data_o);
      check("dis_busy",  {31'd0, busy_o}, 32'd0);
      check("dis_valid", {31'd0, rx_valid_o}, 32'd1);
      check("dis_data",  {24'd0, rx_data_o}, 32'h5A);
      rx_i = 1'b1;
      idle(10);
      cfg_en_i = 1'b1;
      idle(30);
      check("dis_no_char", (n_char - c0) + (n_ovf - o0), 0);
      x0 = n_xfer;
      rx_ready_i = 1'b1;
      idle(3);
      $display("disable drain: data 0x%02h xfers %0d", rx_data_o, n_xfer - x0);
      check("dis_drain_xfer", n_xfer - x0, 1);
      check("dis_drain_data", {24'd0, rx_data_o}, 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/udma_uart_rx_deframer.md
# udma_uart_rx_deframer

UART receive deframer for the uDMA UART peripheral, in the peripheral clock domain. Samples the synchronised serial line at the programmed baud divider, strips start/parity/stop bits and presents each character on a valid/ready port. That port feeds the RX dual-clock FIFO toward the system clock domain. Raises single-cycle parity, overflow and character-received pulses for edge propagation to the system clock domain.

## Interface
- `DIV_WIDTH`, 16: width of the baud divider.
- `clk_i`  in  1: peripheral clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `rx_i`  in  1: raw serial line, asynchronous; idle high.
- `cfg_en_i`  in  1: receiver enable.
- `cfg_div_i`  in  DIV_WIDTH: bit period minus one, in `clk_i` cycles.
- `cfg_parity_en_i`  in  1: even parity bit present.
- `cfg_bits_i`  in  2: data bits; 00=5, 01=6, 10=7, 11=8.
- `cfg_stop_bits_i`  in  1: 0 = one stop bit, 1 = two stop bits.
- `busy_o`  out  1: frame in progress.
- `err_parity_o`  out  1: one-cycle pulse on parity mismatch.
- `err_overflow_o`  out  1: one-cycle pulse when a character is dropped.
- `char_event_o`  out  1: one-cycle pulse when a character is loaded.
- `rx_data_o`  out  8: character, zero-extended above `cfg_bits_i`.
- `rx_valid_o`  out  1: `rx_data_o` valid.
- `rx_ready_i`  in  1: downstream accepts.

## Operation
- **Input synchroniser:** two-flop synchroniser on `rx_i`, reset to 1. All logic uses the synchronised line `rxs`.
- **Baud counter:** width DIV_WIDTH, counts 0..`cfg_div_i`. Bit period is `cfg_div_i`+1 cycles. Config inputs are static while `busy_o`=1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on falling edge of `rxs` while `cfg_en_i`=1. Counter cleared.
  - START: at count `cfg_div_i`>>1, if `rxs`=0 -> DATA with the counter re-phased to mid-bit. Otherwise -> IDLE (glitch; no flags).
  - DATA: sample at each mid-bit, LSB first, into a shift register. After N bits -> PARITY if `cfg_parity_en_i`, else STOP.
  - PARITY: sample. Mismatch is flagged when the frame ends, if XOR of data bits and parity bit ≠ 0.
  - STOP: sample one or two stop bits.
    - All stop bits high: character completes -> IDLE.
    - Any stop bit low: framing error. Character discarded, no flags, FSM waits in IDLE until `rxs`=1 before arming start detection.
- **Completion:**
  - If holding register empty, or `rx_ready_i`=1 in the same cycle: load data, set `rx_valid_o`, pulse `char_event_o`.
  - Else: keep old data, drop new one, pulse `err_overflow_o`.
  - `err_parity_o` pulses in the completion cycle if parity failed. The character is still delivered (or counted as overflow).
- **Handshake:** `rx_valid_o` stays high and `rx_data_o` stable until `rx_valid_o`&&`rx_ready_i`. Transfer clears valid unless a completion loads the same cycle.
- **Disable:** `cfg_en_i`=0 forces IDLE within one cycle and discards any partial frame. The holding register and its handshake are unaffected.
- `busy_o` = state ≠ IDLE.

## Timing
- Reset values:
  - `rx_valid_o`, `busy_o`, all pulses: 0.
  - `rx_data_o`: 0x00.
  - FSM: IDLE.
  - Synchroniser: 1.
- Start detection lags the `rx_i` edge by 2 cycles (synchroniser) + 1.
- `rx_valid_o`/`char_event_o` assert 1 cycle after the last stop-bit mid-sample.
- Reset mid-frame: immediate return to reset values. Next start detection needs `rxs` high then a falling edge.
- Divider: minimum `cfg_div_i`=3. Smaller values are unsupported.

## Configuration
- `UDMA_UART_RX_MAJORITY_EN` defined:
  - Each bit (start check, data, parity, stop) is the 2-of-3 majority of `rxs` at counts mid-1, mid, mid+1.
  - Decision is taken at mid+1, so output latency grows by 1 cycle.
  - Minimum `cfg_div_i` is 4.
- Undefined: single sample at mid (`cfg_div_i`>>1), minimum `cfg_div_i` 3.

## Test plan
- **8N1 basic:** `cfg_div_i`=9, 8N1, send 0xA5 with `rx_ready_i`=1. Expect `rx_data_o`=0xA5, one `char_event_o` pulse, no error pulses, `busy_o` high ~100 cycles.
- **5-bit even parity, two stops:** `cfg_bits_i`=00, parity on, 2 stops, send 0x1F with correct parity 1. Expect 0x1F, no error. Resend with parity 0: `err_parity_o` pulses once, data 0x1F still delivered.
- **Overflow:** `rx_ready_i`=0, send 0x11 then 0x22. Expect `rx_data_o`=0x11 held, `err_overflow_o` pulse at the second completion, one `char_event_o`. Then raise ready: single transfer of 0x11.
- **Glitch start:** `cfg_div_i`=15, low pulse of 3 cycles on `rx_i`. Expect return to IDLE, no valid, no events. A following valid frame 0x3C is received correctly.
- **Framing error:** stop bit driven low on 0x55. Expect no valid and no pulses. Receiver ignores further edges until the line is high, then receives 0x0F correctly.
- **Reset/disable mid-frame:** assert `rst_i` during DATA bit 4. Expect all outputs 0 immediately and the next full frame 0x81 received correctly. Repeat with `cfg_en_i` deasserted: partial frame discarded, prior held character retained.
